uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_fifo.sv | 62 ++++++
 rtl/uart_rx.sv | 199 +++++++++++++++++++
 tb/tb_uart_rx.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default line settings, bit-period helper.
package uart_pkg;

    localparam int CLK_FREQ_DEFAULT = 100_000_000;
    localparam int BAUD_DEFAULT     = 115_200;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    function automatic int clk_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: generic first-word-fall-through synchronous FIFO (RX byte buffer, reusable on the TX side).
// Latency: a push is visible at head_dat/!empty on the cycle after the write edge.
// Backpressure: push while full is ignored unless a pop happens in the same cycle; pop while empty is ignored.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_push  = push && (!full || do_pop);
    assign head_dat = empty ? '0 : mem_q[rd_ptr_q];
    assign count    = count_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver into a FWFT byte FIFO; defining UART_RX_PARITY_EN adds an even-parity bit and parity_error.
// Latency: CLK_PER_BIT/2 + 9*CLK_PER_BIT + 4 clocks from rx falling edge to data_valid (~9.5 bit times).
// Backpressure: data_valid/data_ready pop the head; a byte arriving to a full FIFO with no pop is dropped and sets overflow.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ    = CLK_FREQ_DEFAULT,
    parameter int BAUD        = BAUD_DEFAULT,
    parameter int CLK_PER_BIT = clk_per_bit(CLK_FREQ, BAUD),
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx,
    output logic [7:0]                    data_out,
    output logic                          data_valid,
    input  logic                          data_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_error,
    output logic                          overflow,
    input  logic                          clear_status
`ifdef UART_RX_PARITY_EN
    ,
    output logic                          parity_error
`endif
);

    localparam int CW = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_PER_BIT/2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLK_PER_BIT - 1);

    logic            rx_meta_q;
    logic            rx_s_q;
    rx_state_t       state_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic            push_q;
    logic            frame_error_q;
    logic            overflow_q;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop_eff;
    logic            drop;
`ifdef UART_RX_PARITY_EN
    logic            par_bad_q;
    logic            par_set_q;
    logic            parity_error_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            push_q        <= 1'b0;
            frame_error_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q     <= 1'b0;
            par_set_q     <= 1'b0;
`endif
        end else begin
            push_q        <= 1'b0;
            frame_error_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_set_q     <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_q <= START;
                        cnt_q   <= HALF_LOAD;
                    end
                end
                START: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (rx_s_q) begin
                        state_q <= IDLE;
                    end else begin
                        state_q   <= DATA;
                        cnt_q     <= FULL_LOAD;
                        bit_idx_q <= '0;
                    end
                end
                DATA: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        shift_q <= {rx_s_q, shift_q[7:1]};
                        cnt_q   <= FULL_LOAD;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        par_bad_q <= (rx_s_q != ^shift_q);
                        par_set_q <= (rx_s_q != ^shift_q);
                        cnt_q     <= FULL_LOAD;
                        state_q   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (rx_s_q) begin
                        // Leave mid-stop-bit so a back-to-back start edge is not missed.
`ifdef UART_RX_PARITY_EN
                        push_q <= !par_bad_q;
`else
                        push_q <= 1'b1;
`endif
                        state_q <= IDLE;
                    end else begin
                        frame_error_q <= 1'b1;
                        state_q       <= BREAK;
                    end
                end
                BREAK: begin
                    if (rx_s_q) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push_q),
        .push_dat (shift_q),
        .pop      (data_ready),
        .head_dat (data_out),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign data_valid = !fifo_empty;
    assign pop_eff    = data_ready && !fifo_empty;
    assign drop       = push_q && fifo_full && !pop_eff;

    // Set has priority over clear so a drop coinciding with clear_status is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end else if (clear_status) begin
            overflow_q <= 1'b0;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_error_q <= 1'b0;
        end else if (par_set_q) begin
            parity_error_q <= 1'b1;
        end else if (clear_status) begin
            parity_error_q <= 1'b0;
        end
    end

    assign parity_error = parity_error_q;
`endif

    assign frame_error = frame_error_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames against a byte-queue model.
module tb_uart_rx;

    localparam int CLK_FREQ = 32_000_000;
    localparam int BAUD     = 1_000_000;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int DEPTH    = 16;
    localparam int LAT_MIN  = CPB/2 + 9*CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       data_ready = 1'b0;
    logic       clear_status = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic [4:0] fifo_count;
    logic       frame_error;
    logic       overflow;
`ifdef UART_RX_PARITY_EN
    logic       parity_error;
`endif

    int         n_checks = 0;
    int         n_errors = 0;
    int         fe_cnt = 0;
    logic [7:0] exp_q[$];
    int         exp_ovf = 0;
    bit         rand_en = 1'b0;

    always #5 clk = ~clk;

    uart_rx #(
        .CLK_FREQ    (CLK_FREQ),
        .BAUD        (BAUD),
        .CLK_PER_BIT (CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .fifo_count   (fifo_count),
        .frame_error  (frame_error),
        .overflow     (overflow),
        .clear_status (clear_status)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_error (parity_error)
`endif
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
        end
    endtask

    // Consumer side of the model: every accepted pop must match the oldest expected byte.
    always @(negedge clk) begin
        if (rst_n && frame_error) fe_cnt++;
        if (rst_n && data_valid && data_ready) begin
            if (exp_q.size() == 0) check("pop_extra", int'(data_out), -1);
            else check("pop_data", int'(data_out), int'(exp_q.pop_front()));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_frame(input logic [7:0] b);
        if (exp_q.size() >= DEPTH) exp_ovf = 1;
        else exp_q.push_back(b);
    endtask

    // Drives one frame; abort_at >= 0 stops driving after that many clocks.
    task automatic send_frame(input logic [7:0] b, input bit stop_bit, input bit par_ok, input int abort_at);
        logic [10:0] bits;
        int nb;
        int cyc;
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = b;
`ifdef UART_RX_PARITY_EN
        bits[9]  = (^b) ^ !par_ok;
        bits[10] = stop_bit;
        nb = 11;
`else
        bits[9] = stop_bit;
        nb = 10;
`endif
        cyc = 0;
        for (int i = 0; i < nb; i++) begin
            rx = bits[i];
            for (int c = 0; c < CPB; c++) begin
                if (cyc == abort_at) return;
                @(posedge clk);
                #1;
                cyc++;
            end
        end
    endtask

    task automatic recv_latency(input logic [7:0] b);
        int lat;
        bit seen;
        model_frame(b);
        lat = 0;
        seen = 1'b0;
        fork
            send_frame(b, 1'b1, 1'b1, -1);
            begin
                while (!seen && lat < 2*11*CPB) begin
                    @(posedge clk);
                    lat++;
                    @(negedge clk);
                    if (data_valid) seen = 1'b1;
                end
                check("latency_in_window", int'(seen && lat >= LAT_MIN && lat <= LAT_MIN + 6), 1);
                @(negedge clk);
                check("valid_one_cycle", int'(data_valid), 0);
            end
        join
    endtask

    task automatic drain();
        int t;
        t = 0;
        data_ready = 1'b1;
        while (data_valid && t < 4*DEPTH) begin
            @(posedge clk);
            #1;
            t++;
        end
        data_ready = 1'b0;
        check("drain_model_empty", exp_q.size(), 0);
        check("drain_count", int'(fifo_count), 0);
    endtask

    task automatic check_reset_values();
        check("rst_valid", int'(data_valid), 0);
        check("rst_count", int'(fifo_count), 0);
        check("rst_frame_error", int'(frame_error), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_data_out", int'(data_out), 0);
    endtask

    initial begin
        int fe0;
        int bad_cnt;
        logic [7:0] rb;

        idle(3);
        check_reset_values();
        rst_n = 1'b1;
        idle(2);

        // Two clean frames consumed immediately.
        data_ready = 1'b1;
        fe0 = fe_cnt;
        recv_latency(8'h55);
        recv_latency(8'hA3);
        idle(4);
        check("t1_no_frame_error", fe_cnt - fe0, 0);
        check("t1_no_overflow", int'(overflow), 0);
        check("t1_model_empty", exp_q.size(), 0);
        data_ready = 1'b0;

        // Short low glitch must be ignored.
        fe0 = fe_cnt;
        rx = 1'b0;
        idle(CPB/2 - 4);
        rx = 1'b1;
        idle(2*CPB);
        check("glitch_count", int'(fifo_count), 0);
        check("glitch_frame_error", fe_cnt - fe0, 0);
        model_frame(8'h7E);
        send_frame(8'h7E, 1'b1, 1'b1, -1);
        idle(4);
        check("glitch_next_count", int'(fifo_count), 1);
        drain();

        // Bad stop bit followed by a held-low line.
        fe0 = fe_cnt;
        send_frame(8'h41, 1'b0, 1'b1, -1);
        idle(3*CPB);
        check("break_one_pulse", fe_cnt - fe0, 1);
        check("break_count", int'(fifo_count), 0);
        rx = 1'b1;
        idle(CPB);
        model_frame(8'h42);
        send_frame(8'h42, 1'b1, 1'b1, -1);
        idle(4);
        check("break_next_count", int'(fifo_count), 1);
        drain();
        check("break_still_one", fe_cnt - fe0, 1);

        // Overflow: 17 bytes into a 16-entry FIFO.
        for (int i = 0; i <= 16; i++) begin
            model_frame(8'(i));
            send_frame(8'(i), 1'b1, 1'b1, -1);
        end
        idle(4);
        check("ovf_count", int'(fifo_count), DEPTH);
        check("ovf_flag", int'(overflow), exp_ovf);
        drain();
        check("ovf_sticky", int'(overflow), exp_ovf);
        clear_status = 1'b1;
        idle(1);
        clear_status = 1'b0;
        exp_ovf = 0;
        check("ovf_cleared", int'(overflow), exp_ovf);

        // Full FIFO with a pop in the push cycle keeps the new byte.
        for (int i = 0; i < DEPTH; i++) begin
            model_frame(8'(8'h80 + i));
            send_frame(8'(8'h80 + i), 1'b1, 1'b1, -1);
        end
        idle(4);
        check("full_count", int'(fifo_count), DEPTH);
        fork
            send_frame(8'h99, 1'b1, 1'b1, -1);
            begin
                repeat (LAT_MIN + 3) @(posedge clk);
                #1;
                data_ready = 1'b1;
                @(posedge clk);
                #1;
                data_ready = 1'b0;
            end
        join
        exp_q.push_back(8'h99);
        idle(4);
        check("poppush_count", int'(fifo_count), DEPTH);
        check("poppush_no_ovf", int'(overflow), exp_ovf);
        drain();

        // Reset in the middle of data bit 4 of 0xC3, with a byte already queued.
        model_frame(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b1, -1);
        idle(4);
        check("prerst_count", int'(fifo_count), 1);
        send_frame(8'hC3, 1'b1, 1'b1, 5*CPB + CPB/2);
        rst_n = 1'b0;
        rx = 1'b1;
        exp_q.delete();
        idle(2);
        check_reset_values();
        rst_n = 1'b1;
        idle(2);
        model_frame(8'h3C);
        send_frame(8'h3C, 1'b1, 1'b1, -1);
        idle(4);
        check("postrst_count", int'(fifo_count), 1);
        drain();

`ifdef UART_RX_PARITY_EN
        model_frame(8'h07);
        send_frame(8'h07, 1'b1, 1'b1, -1);
        idle(4);
        check("par_ok_flag", int'(parity_error), 0);
        check("par_ok_count", int'(fifo_count), 1);
        drain();
        send_frame(8'h07, 1'b1, 1'b0, -1);
        idle(4);
        check("par_bad_flag", int'(parity_error), 1);
        check("par_bad_count", int'(fifo_count), 0);
        clear_status = 1'b1;
        idle(1);
        clear_status = 1'b0;
        check("par_cleared", int'(parity_error), 0);
`endif

        // Randomized frames, gaps, stop-bit errors and consumer stalls.
        fe0 = fe_cnt;
        bad_cnt = 0;
        rand_en = 1'b1;
        fork
            begin
                for (int n = 0; n < 24; n++) begin
                    rb = 8'($urandom);
                    if ($urandom_range(0, 7) == 0) begin
                        bad_cnt++;
                        send_frame(rb, 1'b0, 1'b1, -1);
                        rx = 1'b1;
                        idle(CPB);
                    end else begin
                        model_frame(rb);
                        send_frame(rb, 1'b1, 1'b1, -1);
                        idle($urandom_range(0, CPB));
                    end
                end
                idle(8);
                rand_en = 1'b0;
            end
            begin
                while (rand_en) begin
                    data_ready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
                data_ready = 1'b0;
            end
        join
        check("rand_frame_errors", fe_cnt - fe0, bad_cnt);
        check("rand_no_ovf", int'(overflow), exp_ovf);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
